// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, constants and address-width helper for the
//               multi-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_DEPTH  = 32;
    localparam int DEF_NUM_RD = 2;
    localparam int WR_PORTS   = 2;
    localparam int ZERO_ADDR  = 0;

    function automatic int calc_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy flags with write-clear / reserve-set
//               priority and one registered busy read per read port.
//               REGFILE_BYPASS_EN selects post-edge busy for reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int   DEPTH    = DEF_DEPTH,
    parameter int   NUM_RD   = DEF_NUM_RD,
    parameter int   ZERO_REG = 1,
    localparam int  AW       = calc_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WR_PORTS-1:0]    we,
    input  logic [WR_PORTS*AW-1:0] wr_addr,
    input  logic                   rsv_valid,
    input  logic [AW-1:0]          rsv_addr,
    input  logic [NUM_RD*AW-1:0]   rd_addr,
    output logic [NUM_RD-1:0]      rd_busy,
    output logic [DEPTH-1:0]       busy_vec
);

    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [NUM_RD-1:0] rd_busy_q;
    logic [NUM_RD-1:0] rd_busy_d;

    // Writes release first, then a same-edge reserve re-marks the register.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < WR_PORTS; p++) begin
            if (we[p]) begin
                busy_d[wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (rsv_valid) begin
            busy_d[rsv_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_ADDR] = 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign rd_busy_d[i] = busy_d[w_addr];
`else
        assign rd_busy_d[i] = busy_q[w_addr];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q    <= '0;
            rd_busy_q <= '0;
        end else begin
            busy_q    <= busy_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign rd_busy  = rd_busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Two-write, NUM_RD-read register file with registered reads,
//               optional zero register and busy scoreboard. Defining
//               REGFILE_BYPASS_EN forwards same-edge write data to reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter int   DEPTH    = DEF_DEPTH,
    parameter int   NUM_RD   = DEF_NUM_RD,
    parameter int   ZERO_REG = 1,
    localparam int  AW       = calc_aw(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_RD*AW-1:0]      rd_addr,
    output logic [NUM_RD*WIDTH-1:0]   rd_data,
    output logic [NUM_RD-1:0]         rd_busy,
    input  logic [WR_PORTS-1:0]       we,
    input  logic [WR_PORTS*AW-1:0]    wr_addr,
    input  logic [WR_PORTS*WIDTH-1:0] wr_data,
    input  logic                      rsv_valid,
    input  logic [AW-1:0]             rsv_addr,
    output logic [DEPTH-1:0]          busy_vec
);

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [NUM_RD*WIDTH-1:0] rd_data_q;
    logic [NUM_RD*WIDTH-1:0] w_rd_val;

    // Ports are visited in ascending order so port 1 lands last and wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            for (int p = 0; p < WR_PORTS; p++) begin
                if (we[p] && !(ZERO_REG != 0 &&
                               wr_addr[p*AW +: AW] == AW'(ZERO_ADDR))) begin
                    mem_q[wr_addr[p*AW +: AW]] <= wr_data[p*WIDTH +: WIDTH];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    w_addr;
        logic [WIDTH-1:0] w_val;
        assign w_addr = rd_addr[i*AW +: AW];

        always_comb begin
            w_val = mem_q[w_addr];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < WR_PORTS; p++) begin
                if (we[p] && wr_addr[p*AW +: AW] == w_addr) begin
                    w_val = wr_data[p*WIDTH +: WIDTH];
                end
            end
`endif
            if (ZERO_REG != 0 && w_addr == AW'(ZERO_ADDR)) begin
                w_val = '0;
            end
        end

        assign w_rd_val[i*WIDTH +: WIDTH] = w_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= w_rd_val;
        end
    end

    assign rd_data = rd_data_q;

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rd_addr   (rd_addr),
        .rd_busy   (rd_busy),
        .busy_vec  (busy_vec)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Self-checking bench for regfile_mp (4 read ports) against an
//               array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    localparam int W  = 32;
    localparam int D  = 32;
    localparam int NR = 4;
    localparam int AW = 5;

    logic              clk;
    logic              rst;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*W-1:0]   rd_data;
    logic [NR-1:0]     rd_busy;
    logic [1:0]        we;
    logic [2*AW-1:0]   wr_addr;
    logic [2*W-1:0]    wr_data;
    logic              rsv_valid;
    logic [AW-1:0]     rsv_addr;
    logic [D-1:0]      busy_vec;

    regfile_mp #(
        .WIDTH    (W),
        .DEPTH    (D),
        .NUM_RD   (NR),
        .ZERO_REG (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .busy_vec  (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] ref_mem [D];
    logic [D-1:0] ref_busy;
    logic [31:0] exp_d [NR];
    logic        exp_b [NR];

    task automatic idle();
        we = '0; wr_addr = '0; wr_data = '0;
        rsv_valid = 1'b0; rsv_addr = '0; rd_addr = '0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < D; r++) ref_mem[r] = '0;
        ref_busy = '0;
    endtask

    task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
        we[p] = 1'b1;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*W +: W] = d;
    endtask

    // Predicts the read results of the coming edge, applies the edge to the model, advances.
    task automatic tick();
        logic [4:0]  a;
        logic [4:0]  wa;
        logic [31:0] v;
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            v = ref_mem[a];
`ifdef REGFILE_BYPASS_EN
            for (int p = 0; p < 2; p++)
                if (we[p] && wr_addr[p*AW +: AW] == a) v = wr_data[p*W +: W];
`endif
            exp_d[i] = (a == 0) ? 32'h0 : v;
            exp_b[i] = (a == 0) ? 1'b0 : ref_busy[a];
        end
        for (int p = 0; p < 2; p++) begin
            if (we[p]) begin
                wa = wr_addr[p*AW +: AW];
                if (wa != 0) ref_mem[wa] = wr_data[p*W +: W];
                ref_busy[wa] = 1'b0;
            end
        end
        if (rsv_valid && rsv_addr != 0) ref_busy[rsv_addr] = 1'b1;
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            exp_b[i] = (a == 0) ? 1'b0 : ref_busy[a];
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        set_wr(0, 5'd31, 32'hCAFE_F00D);
        rsv_valid = 1'b1; rsv_addr = 5'd31;
        tick();
        idle();
        rd_addr = {4{5'd31}};
        tick();
        #2 rst = 1'b1;
        #1;
        total++;
        if (rd_data !== '0) begin
            bad++; $display("FAIL async_reset rd_data: got %h want 0", rd_data);
        end
        total++;
        if (rd_busy !== '0 || busy_vec !== '0) begin
            bad++; $display("FAIL async_reset busy: got rd_busy=%b busy_vec=%h want 0", rd_busy, busy_vec);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rd_addr = {5'd31, 5'd0, 5'd31, 5'd0};
        tick();
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rd_data[i*W +: W] !== 32'h0 || rd_busy[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_read port%0d: got data=%h busy=%b want 0/0", i, rd_data[i*W +: W], rd_busy[i]);
            end
        end
        total++;
        if (busy_vec !== '0) begin
            bad++; $display("FAIL reset_busy_vec: got %h want 0", busy_vec);
        end
    endtask

    task automatic test_wr_conflict();
        idle();
        set_wr(0, 5'd5, 32'hAAAA_0000);
        set_wr(1, 5'd5, 32'h1234_5678);
        tick();
        idle();
        rd_addr[0 +: AW] = 5'd5;
        tick();
        total++;
        if (rd_data[0 +: W] !== 32'h1234_5678) begin
            bad++; $display("FAIL wr_conflict: got %h want 12345678", rd_data[0 +: W]);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        set_wr(0, 5'd0, 32'hFFFF_FFFF);
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        tick();
        idle();
        tick();
        for (int i = 0; i < NR; i++) begin
            total++;
            if (rd_data[i*W +: W] !== 32'h0 || rd_busy[i] !== 1'b0) begin
                bad++;
                $display("FAIL zero_reg port%0d: got data=%h busy=%b want 0/0", i, rd_data[i*W +: W], rd_busy[i]);
            end
        end
        total++;
        if (busy_vec[0] !== 1'b0) begin
            bad++; $display("FAIL zero_busy_vec: got %b want 0", busy_vec[0]);
        end
    endtask

    task automatic test_raw();
        logic [31:0] want;
        idle();
        set_wr(0, 5'd7, 32'h0000_0011);
        tick();
        idle();
        set_wr(1, 5'd7, 32'hDEAD_BEEF);
        rd_addr[0 +: AW] = 5'd7;
        tick();
`ifdef REGFILE_BYPASS_EN
        want = 32'hDEAD_BEEF;
`else
        want = 32'h0000_0011;
`endif
        total++;
        if (rd_data[0 +: W] !== want) begin
            bad++; $display("FAIL raw_same_edge: got %h want %h", rd_data[0 +: W], want);
        end
        idle();
        rd_addr[0 +: AW] = 5'd7;
        tick();
        total++;
        if (rd_data[0 +: W] !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL raw_next_edge: got %h want deadbeef", rd_data[0 +: W]);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        tick();
        total++;
        if (busy_vec[3] !== 1'b1) begin
            bad++; $display("FAIL sb_reserve: got %b want 1", busy_vec[3]);
        end
        idle();
        tick();
        set_wr(0, 5'd3, 32'h3333_3333);
        rsv_valid = 1'b1; rsv_addr = 5'd3;
        tick();
        total++;
        if (busy_vec[3] !== 1'b1) begin
            bad++; $display("FAIL sb_collision: got %b want 1", busy_vec[3]);
        end
        idle();
        set_wr(1, 5'd3, 32'h3333_4444);
        tick();
        total++;
        if (busy_vec[3] !== 1'b0) begin
            bad++; $display("FAIL sb_release: got %b want 0", busy_vec[3]);
        end
    endtask

    task automatic test_sweep();
        logic [4:0]  a;
        logic [31:0] want;
        for (int r = 1; r < D; r += 2) begin
            idle();
            set_wr(0, 5'(r), 32'(r) * 32'h0101_0101);
            if (r + 1 < D) set_wr(1, 5'(r + 1), 32'(r + 1) * 32'h0101_0101);
            tick();
        end
        for (int c = 0; c < 8; c++) begin
            idle();
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 5'((c * 4 + i * 9) % D);
            tick();
            for (int i = 0; i < NR; i++) begin
                a = 5'((c * 4 + i * 9) % D);
                want = 32'(a) * 32'h0101_0101;
                total++;
                if (rd_data[i*W +: W] !== want) begin
                    bad++;
                    $display("FAIL sweep port%0d addr%0d: got %h want %h", i, a, rd_data[i*W +: W], want);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            idle();
            for (int p = 0; p < 2; p++)
                if ($urandom_range(1, 0) == 1) set_wr(p, 5'($urandom_range(D - 1, 0)), $urandom);
            rsv_valid = ($urandom_range(1, 0) == 1);
            rsv_addr  = 5'($urandom_range(D - 1, 0));
            for (int i = 0; i < NR; i++) rd_addr[i*AW +: AW] = 5'($urandom_range(D - 1, 0));
            // Bias some reads onto the write addresses to exercise collisions.
            if ($urandom_range(3, 0) == 0) rd_addr[0 +: AW] = wr_addr[0 +: AW];
            if ($urandom_range(3, 0) == 0) rd_addr[AW +: AW] = wr_addr[AW +: AW];
            tick();
            for (int i = 0; i < NR; i++) begin
                total++;
                if (rd_data[i*W +: W] !== exp_d[i] || rd_busy[i] !== exp_b[i]) begin
                    bad++;
                    $display("FAIL random c%0d port%0d: got data=%h busy=%b want data=%h busy=%b",
                             c, i, rd_data[i*W +: W], rd_busy[i], exp_d[i], exp_b[i]);
                end
            end
            total++;
            if (busy_vec !== ref_busy) begin
                bad++; $display("FAIL random c%0d busy_vec: got %h want %h", c, busy_vec, ref_busy);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        #12;
        total++;
        if (rd_data !== '0 || rd_busy !== '0 || busy_vec !== '0) begin
            bad++; $display("FAIL power_on_reset: got data=%h busy=%b vec=%h want 0", rd_data, rd_busy, busy_vec);
        end
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_wr_conflict();
        test_zero_reg();
        test_raw();
        test_scoreboard();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file, the next generation of the CPU's single-write, dual-read register block. It provides a configurable number of read ports, two write ports, a hardwired zero register, registered read outputs and a per-register busy scoreboard. It sits between decode (read/reserve) and write-back (write/release) in the datapath.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, ≥ 4); AW = log2(DEPTH)
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as 0, and writes and reserves to it are ignored
- clk  in  1  clock, all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- rd_addr  in  NUM_RD*AW  read addresses; port i is bits [i*AW +: AW]
- rd_data  out  NUM_RD*WIDTH  registered read data, packed the same way as rd_addr
- rd_busy  out  NUM_RD  registered busy flag of the addressed register
- we  in  2  write enables, write ports 0 and 1
- wr_addr  in  2*AW  write addresses
- wr_data  in  2*WIDTH  write data
- rsv_valid  in  1  reserve request: mark a register busy
- rsv_addr  in  AW  register to reserve
- busy_vec  out  DEPTH  live (unregistered) scoreboard state

## Operation
- Storage: DEPTH × WIDTH flops.
  - rst clears every register, the scoreboard, rd_data and rd_busy to 0.
- Write:
  - At the edge, each port with we=1 stores wr_data into wr_addr.
  - When both ports target the same address, port 1 wins.
  - With ZERO_REG=1, writes to address 0 are dropped.
- Read:
  - At each edge, port i captures the addressed register into rd_data[i] and its busy bit into rd_busy[i].
  - With ZERO_REG=1, address 0 always yields data 0 and busy 0.
- Scoreboard:
  - A write from either port clears the busy bit of its address.
  - rsv_valid=1 sets the busy bit of rsv_addr.
  - When a reserve and a write hit the same address on the same edge, the reserve wins and the bit ends at 1 (a new producer has been issued).
  - Reserving an already-busy register keeps it busy; this is not an error.
  - With ZERO_REG=1, reserves of address 0 are ignored.
- No flow control. Every request is accepted in the cycle it is presented.

## Timing
- Read latency is 1 cycle. The address is sampled at edge N, and rd_data/rd_busy are valid after edge N until edge N+1.
- Write latency: data is stored at edge N. Without bypass, a read sampled at edge N returns the old value, and the new value is visible from reads sampled at edge N+1 onward.
- busy_vec updates at the edge and is combinationally visible after it.
- Same-edge collisions are resolved in this order: write-port priority, then the write clears busy, then the reserve sets busy.
- rst asserted mid-operation:
  - Outputs go to 0 immediately, regardless of the clock.
  - Requests pending on the deasserting edge are ignored. The first edge with rst=0 acts normally.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read sampled at edge N whose address matches an active write at edge N returns that write data, using port-1 priority.
  - rd_busy then reflects the post-edge scoreboard value (write clear and reserve applied).
  - The zero-register rule still takes precedence.
- Undefined:
  - Reads return pre-edge storage and the pre-edge busy bit.
  - No comparators or forwarding muxes are instantiated.

## Structure
- Package regfile_pkg holds:
  - the defaults for WIDTH, DEPTH and NUM_RD;
  - the clog2-based AW helper function;
  - the WR_PORTS=2 constant;
  - the zero-register address constant.
- Sub-module regfile_scoreboard holds:
  - the DEPTH busy flops, the set/clear priority logic and the busy_vec output;
  - a read port for each rd_addr.
- Storage, write arbitration and the read and bypass muxes stay in regfile_mp.

## Test plan
- Reset then read:
  - Sequence: assert rst mid-cycle, release it, then read addresses 0 and 31.
  - Required: rd_data=0 and rd_busy=0 on both ports; busy_vec=0.
- Write port conflict:
  - Sequence: we=2'b11, both wr_addr=5, data 0xAAAA_0000 on port 0 and 0x1234_5678 on port 1; read address 5 on the next edge.
  - Required: 0x1234_5678.
- Zero register:
  - Sequence: write 0xFFFF_FFFF to address 0, and set rsv_valid with rsv_addr=0.
  - Required: reads of address 0 return 0 with busy 0; busy_vec[0]=0.
- Same-edge read-after-write:
  - Sequence: write 0xDEAD_BEEF to address 7 while reading address 7 (previously 0x11).
  - Required: returns 0xDEAD_BEEF with REGFILE_BYPASS_EN defined, 0x11 without it; a read on the next edge returns 0xDEAD_BEEF in both builds.
- Scoreboard collision:
  - Sequence: reserve address 3; two cycles later, write address 3 and reserve address 3 on the same edge; then write address 3 alone.
  - Required: busy_vec[3] is 1 after the first edge, still 1 after the collision, and 0 after the lone write.
- Multi-port sweep (NUM_RD=4):
  - Sequence: fill registers 1..31 with value = address×0x0101_0101, then read four distinct addresses per cycle.
  - Required: each port returns its own value one cycle after the address is sampled.
